// File: rtl/agent_pkg.sv
// agent_pkg: shared types, widths and LFSR helpers for the bandit learning agent.
//   agent_state_t : FSM state encoding
//   Q_W / A_W     : value-estimate width / action output width
//   LFSR_MASK     : Galois feedback taps (right-shifting form)
//   LFSR_INIT     : constant folded into the user seed
package agent_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UPDATE,
    SCAN,
    SELECT,
    DONE
  } agent_state_t;

  localparam int          Q_W       = 16;
  localparam int          A_W       = 9;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  // One Galois step, shifting right; taps applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  // An all-zero LFSR would lock up, so a zero effective seed is forced to 1.
  function automatic logic [15:0] eff_seed(input logic [15:0] seed);
    logic [15:0] x;
    x = seed ^ LFSR_INIT;
    return (x == 16'h0000) ? 16'h0001 : x;
  endfunction

endpackage

// File: rtl/agent_lfsr16.sv
// lfsr16: 16-bit Galois LFSR used as the agent's exploration source.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset, loads seed
//   seed  : reset value (expected to be a constant)
//   en    : advance one step on this clock edge
//   state : current LFSR value
module lfsr16
  import agent_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= seed;
    end else if (en) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/agent.sv
// agent: bandit-style value learner with epsilon-greedy action selection.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   v   : reward valid, one-cycle pulse, accepted only in IDLE
//   r   : reward for the currently issued action (unsigned)
//   a   : current action index, zero-extended, < N_ACT
//   d   : one-cycle registered pulse when the next action is issued
//
// state  | meaning
// IDLE   | wait for v, latch r
// UPDATE | Q[a] moves toward r by 2^-ALPHA_SHIFT of the error
// SCAN   | walk Q[0..N_ACT-1], one entry per cycle, track argmax
// SELECT | step LFSR, explore or exploit, drive new a, raise d
// DONE   | d high for this cycle, back to IDLE
module agent
  import agent_pkg::*;
#(
  parameter int SEED        = 0,
  parameter int N_ACT       = 64,
  parameter int ALPHA_SHIFT = 1,
  parameter int EPS         = 20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           v,
  input  logic [15:0]    r,
  output logic [A_W-1:0] a,
  output logic           d
);

  localparam int               IDX_W    = $clog2(N_ACT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ACT - 1);
  localparam logic [15:0]      IDX_MASK = 16'(N_ACT - 1);
  localparam logic [7:0]       EPS_T    = 8'(EPS);
  localparam logic [15:0]      SEED_EFF = eff_seed(16'(SEED));

  agent_state_t      state;
  logic [Q_W-1:0]    q [N_ACT];
  logic [Q_W-1:0]    r_lat;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  best;
  logic [Q_W-1:0]    best_val;
  logic [15:0]       lfsr_state;
  logic [15:0]       lfsr_nxt;
  logic [Q_W-1:0]    q_cur;
  logic [Q_W-1:0]    q_upd;
  logic signed [Q_W:0] diff;
  logic signed [Q_W:0] delta;
  logic              explore;
  logic [A_W-1:0]    rand_a;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (SEED_EFF),
    .en    (state == SELECT),
    .state (lfsr_state)
  );

  always_comb begin
    q_cur = q[a[IDX_W-1:0]];
    // 17-bit signed error; the arithmetic shift keeps the sign, so the sum
    // always lands back in 0..65535 and modulo-2^16 addition is exact.
    diff  = signed'({1'b0, r_lat}) - signed'({1'b0, q_cur});
    delta = diff >>> ALPHA_SHIFT;
    q_upd = q_cur + delta[Q_W-1:0];
  end

  // SELECT acts on the post-step LFSR value, which the sub-module registers
  // at the same edge.
  always_comb begin
    lfsr_nxt = lfsr_step(lfsr_state);
    explore  = {1'b0, lfsr_nxt[15:9]} < EPS_T;
    rand_a   = A_W'(lfsr_nxt & IDX_MASK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      a        <= '0;
      d        <= 1'b0;
      r_lat    <= '0;
      idx      <= '0;
      best     <= '0;
      best_val <= '0;
      for (int i = 0; i < N_ACT; i++) begin
        q[i] <= '0;
      end
    end else begin
      d <= 1'b0;
      case (state)
        IDLE: begin
          if (v) begin
            r_lat <= r;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          q[a[IDX_W-1:0]] <= q_upd;
          idx             <= '0;
          state           <= SCAN;
        end
        SCAN: begin
          // Strict compare: on ties the earlier (lower) index is kept.
          if ((idx == '0) || (q[idx] > best_val)) begin
            best     <= idx;
            best_val <= q[idx];
          end
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            state <= SELECT;
          end
        end
        SELECT: begin
          a     <= explore ? rand_a : A_W'(best);
          d     <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_agent.sv
// tb_agent: directed and model-checked bench for agent.
// Three instances share the clock: u_g (EPS=0), u_r (EPS=128), u_e (EPS=20).
module tb_agent;

  localparam int N   = 64;
  localparam int LAT = N + 2;

  typedef struct {
    logic [15:0] r;
    int          q0;
    int          a;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_s [3];
  logic        v_s   [3];
  logic [15:0] r_s   [3];
  logic [8:0]  a_s   [3];
  logic        d_s   [3];

  int checks = 0;
  int errors = 0;

  int          qm   [3][N];
  logic [15:0] lm   [3];
  int          am   [3];
  int          epsm [3] = '{0, 128, 20};
  int          seedm[3] = '{0, 'h5A5A, 'hACE1};

  vec_t tbl [14];

  always #5 clk = ~clk;

  agent #(.SEED(0), .N_ACT(N), .ALPHA_SHIFT(1), .EPS(0)) u_g (
    .clk(clk), .rst(rst_s[0]), .v(v_s[0]), .r(r_s[0]), .a(a_s[0]), .d(d_s[0]));
  agent #(.SEED('h5A5A), .N_ACT(N), .ALPHA_SHIFT(1), .EPS(128)) u_r (
    .clk(clk), .rst(rst_s[1]), .v(v_s[1]), .r(r_s[1]), .a(a_s[1]), .d(d_s[1]));
  agent #(.SEED('hACE1), .N_ACT(N), .ALPHA_SHIFT(1), .EPS(20)) u_e (
    .clk(clk), .rst(rst_s[2]), .v(v_s[2]), .r(r_s[2]), .a(a_s[2]), .d(d_s[2]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int u);
    logic [15:0] x;
    for (int i = 0; i < N; i++) qm[u][i] = 0;
    am[u] = 0;
    x = 16'(seedm[u]) ^ 16'hACE1;
    lm[u] = (x == 16'h0000) ? 16'h0001 : x;
  endtask

  task automatic model_round(input int u, input int rv);
    int df;
    int b;
    logic [15:0] l;
    df = rv - qm[u][am[u]];
    qm[u][am[u]] = qm[u][am[u]] + (df >>> 1);
    b = 0;
    for (int i = 1; i < N; i++) if (qm[u][i] > qm[u][b]) b = i;
    l = lm[u];
    l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    lm[u] = l;
    if (int'(l[15:9]) < epsm[u]) am[u] = int'(l[5:0]);
    else am[u] = b;
  endtask

  task automatic do_round(input int u, input logic [15:0] rv, input string nm);
    int n;
    bit got;
    model_round(u, int'(rv));
    @(negedge clk);
    v_s[u] = 1'b1;
    r_s[u] = rv;
    @(posedge clk);
    #1;
    v_s[u] = 1'b0;
    r_s[u] = 16'h0;
    n = 0;
    got = 0;
    while (n < LAT + 20 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (d_s[u]) got = 1;
    end
    chk({nm, " latency"}, got ? n : -1, LAT);
    if (got) begin
      chk({nm, " a"}, int'(a_s[u]), am[u]);
      @(posedge clk);
      #1;
      chk({nm, " d width"}, int'(d_s[u]), 0);
      chk({nm, " a hold"}, int'(a_s[u]), am[u]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // r, expected Q[0] after the round, expected a (EPS=0, ALPHA_SHIFT=1)
    tbl[0]  = '{16'd1000,  500,   0};
    tbl[1]  = '{16'd0,     250,   0};
    tbl[2]  = '{16'd0,     125,   0};
    tbl[3]  = '{16'd0,     62,    0};
    tbl[4]  = '{16'd0,     31,    0};
    tbl[5]  = '{16'd0,     15,    0};
    tbl[6]  = '{16'd0,     7,     0};
    tbl[7]  = '{16'd0,     3,     0};
    tbl[8]  = '{16'd0,     1,     0};
    tbl[9]  = '{16'd0,     0,     0};
    tbl[10] = '{16'd0,     0,     0};
    tbl[11] = '{16'd3,     1,     0};
    tbl[12] = '{16'd65535, 32768, 0};
    tbl[13] = '{16'd0,     16384, 0};

    for (int u = 0; u < 3; u++) begin
      rst_s[u] = 1'b0;
      v_s[u]   = 1'b1;
      r_s[u]   = 16'd1234;
      model_reset(u);
    end

    // Reset held with v high: no activity.
    repeat (5) begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
        chk("reset d", int'(d_s[u]), 0);
        chk("reset a", int'(a_s[u]), 0);
      end
    end
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      rst_s[u] = 1'b1;
      v_s[u]   = 1'b0;
      r_s[u]   = 16'h0;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("idle no d", int'(d_s[0]), 0);
    end

    fork
      begin : greedy
        int n;
        bit got;
        int extra;
        int dcnt;
        for (int i = 0; i < 14; i++) begin
          do_round(0, tbl[i].r, "tbl");
          chk("tbl q0", int'(u_g.q[0]), tbl[i].q0);
          chk("tbl a", int'(a_s[0]), tbl[i].a);
        end

        // v during SCAN and during DONE must be ignored.
        model_round(0, 2000);
        @(negedge clk);
        v_s[0] = 1'b1;
        r_s[0] = 16'd2000;
        @(posedge clk);
        #1;
        v_s[0] = 1'b0;
        n = 0;
        got = 0;
        while (n < LAT + 20 && !got) begin
          @(posedge clk);
          #1;
          n++;
          if (n == 10) begin
            v_s[0] = 1'b1;
            r_s[0] = 16'd60000;
          end else if (n == 11) begin
            v_s[0] = 1'b0;
          end
          if (d_s[0]) got = 1;
        end
        chk("scan v latency", got ? n : -1, LAT);
        v_s[0] = 1'b1;
        r_s[0] = 16'd60000;
        @(posedge clk);
        #1;
        v_s[0] = 1'b0;
        chk("done v d width", int'(d_s[0]), 0);
        extra = 0;
        repeat (80) begin
          @(posedge clk);
          #1;
          if (d_s[0]) extra++;
        end
        chk("ignored v extra d", extra, 0);
        chk("ignored v q0", int'(u_g.q[0]), 9192);
        chk("ignored v a", int'(a_s[0]), 0);

        // Reset in the middle of SCAN aborts without a d pulse.
        @(negedge clk);
        v_s[0] = 1'b1;
        r_s[0] = 16'd1000;
        @(posedge clk);
        #1;
        v_s[0] = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_s[0] = 1'b0;
        dcnt = 0;
        repeat (3) begin
          @(posedge clk);
          #1;
          if (d_s[0]) dcnt++;
          chk("mid reset a", int'(a_s[0]), 0);
        end
        @(negedge clk);
        rst_s[0] = 1'b1;
        repeat (80) begin
          @(posedge clk);
          #1;
          if (d_s[0]) dcnt++;
        end
        chk("mid reset no d", dcnt, 0);
        chk("mid reset q0", int'(u_g.q[0]), 0);
        model_reset(0);
        do_round(0, 16'd1000, "post reset");
        chk("post reset q0", int'(u_g.q[0]), 500);
      end
      begin : random_all
        for (int i = 0; i < 250; i++) begin
          do_round(1, 16'($urandom_range(0, 65535)), "eps128");
        end
      end
      begin : eps20
        for (int i = 0; i < 80; i++) begin
          do_round(2, 16'($urandom_range(0, 65535)), "eps20");
        end
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
